// File: rtl/aes_pkg.sv
// aes_pkg: shared AES-128 key-schedule types, constants and byte-level helpers
package aes_pkg;
  localparam int KEY_W = 128;
  localparam int NUM_ROUNDS = 10;
  typedef logic [3:0] round_idx_t;
  typedef logic [127:0] key_t;
  typedef enum logic [1:0] {KS_IDLE, KS_EXPAND, KS_READY} ks_state_t;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [87:0] RCON = 88'h00_01_02_04_08_10_20_40_80_1b_36;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[2047 - 8 * int'(b) -: 8];
  endfunction
  function automatic logic [7:0] rcon(input round_idx_t r);
    return (int'(r) > NUM_ROUNDS) ? 8'h00 : RCON[87 - 8 * int'(r) -: 8];
  endfunction
endpackage

// File: rtl/Key_gen.sv
// Key_gen: combinational AES-128 single-round key expansion step
module Key_gen
  import aes_pkg::*;
(
  input  key_t       key_in,
  input  round_idx_t round,
  output key_t       key_out
);
  logic [31:0] rot, t, w4, w5, w6, w7;
  // RotWord/SubWord/Rcon on the last word, then the running XOR chain
  always_comb begin
    rot = {key_in[23:0], key_in[31:24]};
    t = {sbox(rot[31:24]) ^ rcon(round), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    w4 = key_in[127:96] ^ t;
    w5 = key_in[95:64] ^ w4;
    w6 = key_in[63:32] ^ w5;
    w7 = key_in[31:0] ^ w6;
    key_out = {w4, w5, w6, w7};
  end
endmodule

// File: rtl/key_sched_ctrl.sv
// key_sched_ctrl: expands an AES-128 key into 11 stored round keys, one round per clock
module key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_W = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  key_t       key_in,
  input  logic       clear,
  output logic       busy,
  output logic       done,
  output logic       keys_ready,
  input  logic       rd_en,
  input  round_idx_t rd_round,
  output key_t       rd_key,
  output logic       rd_valid
);
  if (KEY_W != 128 || NUM_ROUNDS != 10) begin : g_bad_cfg
    $error("key_sched_ctrl supports only KEY_W=128 and NUM_ROUNDS=10");
  end
  localparam round_idx_t LAST = round_idx_t'(NUM_ROUNDS);
  ks_state_t  state, nxt;
  round_idx_t rnd;
  key_t       wkey, kg_key;
  key_t       store [NUM_ROUNDS+1];
  logic       rd_ok;
  Key_gen u_key_gen (
    .key_in (wkey),
    .round  (busy ? rnd : '0),
    .key_out(kg_key)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= KS_IDLE;
    else state <= nxt;
  // next state: clear dominates, EXPAND ignores start, IDLE/READY accept it
  always_comb
    nxt = clear ? KS_IDLE :
          (state == KS_EXPAND) ? ((rnd == LAST) ? KS_READY : KS_EXPAND) :
          start ? KS_EXPAND : state;
  // state-decoded status outputs
  always_comb begin
    busy = state == KS_EXPAND;
    keys_ready = state == KS_READY;
    rd_ok = keys_ready && rd_round <= LAST;
  end
  // key store, working key and round counter; clear zeroises every entry at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rnd <= '0;
      wkey <= '0;
      done <= 1'b0;
      for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        rnd <= '0;
        wkey <= '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
      end else if (start && !busy) begin
        store[0] <= key_in;
        wkey <= key_in;
        rnd <= 4'd1;
      end else if (busy) begin
        store[rnd] <= kg_key;
        wkey <= kg_key;
        rnd <= (rnd == LAST) ? '0 : rnd + 4'd1;
        done <= rnd == LAST;
      end
    end
  // registered read port; nothing is exposed unless the full schedule is ready
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_key <= '0;
      rd_valid <= 1'b0;
    end else if (clear) begin
      rd_key <= '0;
      rd_valid <= 1'b0;
    end else if (rd_en) begin
      rd_key <= rd_ok ? store[rd_round] : '0;
      rd_valid <= rd_ok;
    end else rd_valid <= 1'b0;
endmodule

// File: tb/tb_key_sched_ctrl.sv
// tb_key_sched_ctrl: scoreboard bench for the AES-128 key schedule controller
module tb_key_sched_ctrl;
  import aes_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, clear = 1'b0, rd_en = 1'b0;
  key_t key_in = '0;
  round_idx_t rd_round = '0;
  logic busy, done, keys_ready, rd_valid;
  key_t rd_key;
  int vectors = 0, miscompares = 0;
  logic [128:0] exp_q[$];
  localparam key_t FKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  key_t fips [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  key_t zk [0:10] = '{
    128'h0, 128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0,
    128'h0, 128'h0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
  localparam logic [10:0] ALL = 11'h7ff, ZMASK = 11'b100_0000_0111;

  always #5 clk = ~clk;

  key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .clear(clear),
    .busy(busy), .done(done), .keys_ready(keys_ready), .rd_en(rd_en),
    .rd_round(rd_round), .rd_key(rd_key), .rd_valid(rd_valid)
  );

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic status(input string tag, input logic eb, input logic ed, input logic er);
    check(tag, {126'b0, busy, done, keys_ready}, {126'b0, eb, ed, er});
  endtask

  task automatic rd(input round_idx_t idx, input logic v, input key_t k);
    rd_en = 1'b1;
    rd_round = idx;
    exp_q.push_back({v, v ? k : 128'h0});
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial forever begin
    logic fire;
    logic [128:0] e;
    @(posedge clk);
    fire = rd_en;
    #1;
    if (fire) begin
      check("sb_depth", 129'(exp_q.size() > 0), 129'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd", {rd_valid, rd_key}, e);
      end
    end
  end

  task automatic expand(input key_t k, input key_t tab [0:10], input logic [10:0] mask,
                        input int dup_at, input int clr_at, input int rst_at,
                        input logic rd_old, input key_t old);
    @(negedge clk);
    start = 1'b1;
    key_in = k;
    if (rd_old) begin
      rd_en = 1'b1;
      rd_round = 4'd10;
      exp_q.push_back({1'b1, old});
    end
    @(negedge clk);
    start = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 10; i++) begin
      status($sformatf("expand%0d", i), 1'b1, 1'b0, 1'b0);
      rd_en = 1'b1;
      rd_round = round_idx_t'(i);
      exp_q.push_back('0);
      if (i == dup_at) begin
        start = 1'b1;
        key_in = {$urandom, $urandom, $urandom, $urandom};
      end
      if (i == clr_at) begin
        clear = 1'b1;
        start = 1'b1;
      end
      if (i == rst_at) begin
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        status("rst_async", 1'b0, 1'b0, 1'b0);
        check("rst_async_rd", {rd_valid, rd_key}, '0);
        rd_en = 1'b0;
        return;
      end
      @(negedge clk);
      start = 1'b0;
      clear = 1'b0;
      if (i == clr_at) begin
        rd_en = 1'b0;
        status("clear", 1'b0, 1'b0, 1'b0);
        return;
      end
    end
    rd_en = 1'b0;
    status("done_pulse", 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    status("ready", 1'b0, 1'b0, 1'b1);
    for (int j = 0; j <= 10; j++)
      if (mask[j]) rd(round_idx_t'(j), 1'b1, tab[j]);
    @(negedge clk);
    check("rd_hold", {rd_valid, rd_key}, {1'b0, tab[10]});
  endtask

  initial begin
    #12;
    status("reset", 1'b0, 1'b0, 1'b0);
    check("reset_rd", {rd_valid, rd_key}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    expand(FKEY, fips, ALL, -1, -1, -1, 1'b0, '0);
    rd(4'd11, 1'b0, '0);
    rd(4'd15, 1'b0, '0);
    rd(4'd0, 1'b1, fips[0]);
    expand(FKEY, fips, ALL, 3, -1, -1, 1'b1, fips[10]);
    expand('0, zk, ZMASK, -1, -1, -1, 1'b1, fips[10]);
    expand(FKEY, fips, ALL, -1, 4, -1, 1'b0, '0);
    for (int j = 0; j <= 10; j++) rd(round_idx_t'(j), 1'b0, '0);
    repeat (12) @(negedge clk);
    status("idle_after_clear", 1'b0, 1'b0, 1'b0);
    expand(FKEY, fips, ALL, -1, -1, -1, 1'b0, '0);
    expand('0, zk, ZMASK, -1, -1, 5, 1'b0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    expand('0, zk, ZMASK, -1, -1, -1, 1'b0, '0);
    repeat (3) @(negedge clk);
    check("sb_drain", 129'(exp_q.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
